// File: rtl/spi_slave_bridge.sv
// SPI mode-0 slave that turns 8-bit command + 32-bit data frames into
// single-cycle register read/write strobes on the clk_1x domain.
module spi_slave_bridge #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_1x,
  input  logic              rst_1x,
  input  logic              spi_s_clk,
  input  logic              spi_cs_l,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_address,
  output logic              reg_rden,
  input  logic [31:0]       reg_readdata,
  output logic              reg_wren,
  output logic [31:0]       reg_writedata,
  output logic              frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD, DONE} state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, fill;
  logic       s_sclk, s_cs_l, s_mosi;
  logic       sclk_d, cs_d, armed;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [5:0] bit_cnt, cnt_inc;
  logic [7:0] cmd_sr, cmd_next;
  logic [31:0] rx_sr, rx_next, tx_sr;
  logic       rd_load;
  logic       cmd_done, data_done;

  // Input synchronizers; fill marks when the chain holds only real samples.
  always_ff @(posedge clk_1x or posedge rst_1x) begin
    if (rst_1x) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_s_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_l};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s_sclk = sclk_sync[SYNC_STAGES-1];
  assign s_cs_l = cs_sync[SYNC_STAGES-1];
  assign s_mosi = mosi_sync[SYNC_STAGES-1];

  // armed stays low until a genuine high on chip select has been observed,
  // so a select already held low across reset never starts a frame.
  always_ff @(posedge clk_1x or posedge rst_1x) begin
    if (rst_1x) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
      armed  <= 1'b0;
    end else begin
      sclk_d <= s_sclk;
      cs_d   <= s_cs_l;
      armed  <= armed | (fill[SYNC_STAGES-1] & s_cs_l);
    end
  end

  assign sclk_rise = s_sclk & ~sclk_d;
  assign sclk_fall = ~s_sclk & sclk_d;
  assign cs_rise   = s_cs_l & ~cs_d;
  assign cs_fall   = armed & cs_d & ~s_cs_l;

  assign cnt_inc   = (bit_cnt == 6'h3f) ? bit_cnt : bit_cnt + 6'd1;
  assign cmd_next  = {cmd_sr[6:0], s_mosi};
  assign rx_next   = {rx_sr[30:0], s_mosi};
  assign cmd_done  = sclk_rise && (bit_cnt == 6'd7);
  assign data_done = sclk_rise && (bit_cnt == 6'd31);

  always_ff @(posedge clk_1x or posedge rst_1x) begin
    if (rst_1x) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD:     if (cmd_done) state_d = cmd_next[7] ? WR : RD;
      WR:      if (data_done) state_d = DONE;
      RD:      if (data_done) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Deselect wins over any SCLK edge seen in the same cycle.
    if (cs_rise) state_d = IDLE;
  end

  always_ff @(posedge clk_1x or posedge rst_1x) begin
    if (rst_1x) begin
      spi_miso      <= 1'b0;
      spi_miso_oe   <= 1'b0;
      reg_address   <= '0;
      reg_rden      <= 1'b0;
      reg_wren      <= 1'b0;
      reg_writedata <= '0;
      frame_err     <= 1'b0;
      bit_cnt       <= '0;
      cmd_sr        <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      rd_load       <= 1'b0;
    end else begin
      reg_rden  <= 1'b0;
      reg_wren  <= 1'b0;
      frame_err <= 1'b0;
      rd_load   <= reg_rden;
      // Responder data arrives the cycle after the read strobe.
      if (rd_load) tx_sr <= reg_readdata;
      if (cs_rise) begin
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        frame_err   <= (state == CMD) || (state == WR) || (state == RD);
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              bit_cnt     <= '0;
              spi_miso_oe <= 1'b1;
              spi_miso    <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_sr <= cmd_next;
              if (cmd_done) begin
                reg_address <= cmd_next[ADDR_W-1:0];
                bit_cnt     <= '0;
                reg_rden    <= ~cmd_next[7];
              end else begin
                bit_cnt <= cnt_inc;
              end
            end
          end
          WR: begin
            if (sclk_rise) begin
              rx_sr   <= rx_next;
              bit_cnt <= cnt_inc;
              if (data_done) begin
                reg_writedata <= rx_next;
                reg_wren      <= 1'b1;
              end
            end
          end
          RD: begin
            if (sclk_fall) begin
              spi_miso <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
            end
            if (sclk_rise) bit_cnt <= cnt_inc;
          end
          DONE:    spi_miso <= 1'b0;
          default: spi_miso <= 1'b0;
        endcase
      end
    end
  end

endmodule
